// File: rtl/lfsr_prbs_check.sv
// Self-synchronising PRBS checker: seeds its LFSR from the last LFSR_WIDTH received bits of each
// word, predicts the next word, and reports per-bit mismatches, lock state and a saturating count.
module lfsr_prbs_check #(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter                        LFSR_CONFIG   = "FIBONACCI",
  parameter bit                    REVERSE       = 1'b0,
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    LOCK_COUNT    = 4,
  parameter int                    UNLOCK_ERR    = 4,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_valid,
  input  logic                     clear_errors,
  output logic                     locked,
  output logic [DATA_WIDTH-1:0]    error_out,
  output logic                     error_valid,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic                     sync_loss
);

  localparam int GW    = $clog2(LOCK_COUNT + 1);
  localparam int BW    = $clog2(UNLOCK_ERR + 1);
  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W = ((ERR_CNT_WIDTH > PC_W) ? ERR_CNT_WIDTH : PC_W) + 1;
  localparam logic [GW-1:0]         GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0]         BAD_LAST  = BW'(UNLOCK_ERR - 1);
  localparam logic [SUM_W-1:0]      CNT_MAX   = (SUM_W'(1) << ERR_CNT_WIDTH) - SUM_W'(1);
  // Poly bit i (i >= 1) is the x^i tap and reads state bit i-1; x^W and x^0 are implicit.
  localparam logic [LFSR_WIDTH-1:0] TAP_MASK  = LFSR_POLY >> 1;

  if (DATA_WIDTH < LFSR_WIDTH) begin : g_err_width
    $error("lfsr_prbs_check: DATA_WIDTH must be >= LFSR_WIDTH");
  end
  if (LOCK_COUNT == 0 || UNLOCK_ERR == 0) begin : g_err_count
    $error("lfsr_prbs_check: LOCK_COUNT and UNLOCK_ERR must be non-zero");
  end
  if (LFSR_CONFIG != "FIBONACCI") begin : g_err_config
    $error("lfsr_prbs_check: only FIBONACCI is supported");
  end

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  state_t                   r_state, w_state_next;
  logic [LFSR_WIDTH-1:0]    r_seed, w_seed_next, w_rx_seed;
  logic [GW-1:0]            r_good, w_good_next;
  logic [BW-1:0]            r_bad, w_bad_next;
  logic [DATA_WIDTH-1:0]    r_error_out, w_error_out_next;
  logic                     r_error_valid, w_error_valid_next;
  logic                     r_sync_loss, w_sync_loss_next;
  logic [ERR_CNT_WIDTH-1:0] r_error_count, w_error_count_next;
  logic [DATA_WIDTH-1:0]    w_mism;
  logic [PC_W-1:0]          w_add;
  logic [SUM_W-1:0]         w_sum;

  function automatic logic [DATA_WIDTH-1:0] predict(input logic [LFSR_WIDTH-1:0] seed);
    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;
    logic [DATA_WIDTH-1:0] w;
    s = seed;
    w = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      fb = s[LFSR_WIDTH-1] ^ (^(s & TAP_MASK));
      if (REVERSE) w[j] = fb;
      else         w[DATA_WIDTH-1-j] = fb;
      s = {s[LFSR_WIDTH-2:0], fb};
    end
    return w;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] d);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + PC_W'(d[i]);
    return c;
  endfunction

  // The most recently generated bit lands in state bit 0.
  for (genvar gi = 0; gi < LFSR_WIDTH; gi++) begin : g_seed
    assign w_rx_seed[gi] = REVERSE ? data_in[DATA_WIDTH-1-gi] : data_in[gi];
  end

  assign w_mism = data_in ^ predict(r_seed);
  assign w_sum  = SUM_W'(r_error_count) + SUM_W'(w_add);

  always_comb begin
    w_state_next       = r_state;
    w_seed_next        = r_seed;
    w_good_next        = r_good;
    w_bad_next         = r_bad;
    w_error_out_next   = r_error_out;
    w_error_valid_next = 1'b0;
    w_sync_loss_next   = 1'b0;
    w_add              = '0;
    if (data_in_valid) begin
      w_seed_next = w_rx_seed;
      case (r_state)
        ST_SEARCH: begin
          w_good_next  = '0;
          w_bad_next   = '0;
          w_state_next = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (w_mism == '0) begin
            if (r_good == GOOD_LAST) begin
              w_good_next  = '0;
              w_bad_next   = '0;
              w_state_next = ST_LOCKED;
            end else begin
              w_good_next = r_good + GW'(1);
            end
          end else begin
            w_good_next = '0;
          end
        end
        ST_LOCKED: begin
          w_error_out_next   = w_mism;
          w_error_valid_next = 1'b1;
          w_add              = popcount(w_mism);
          if (w_mism != '0) begin
            if (r_bad == BAD_LAST) begin
              w_bad_next       = '0;
              w_sync_loss_next = 1'b1;
              w_state_next     = ST_SEARCH;
            end else begin
              w_bad_next = r_bad + BW'(1);
            end
          end else begin
            w_bad_next = '0;
          end
        end
        default: w_state_next = ST_SEARCH;
      endcase
    end
    // A clear discards whatever the concurrent word would have added.
    if (clear_errors)        w_error_count_next = '0;
    else if (w_sum > CNT_MAX) w_error_count_next = '1;
    else                     w_error_count_next = w_sum[ERR_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_SEARCH;
      r_seed        <= '0;
      r_good        <= '0;
      r_bad         <= '0;
      r_error_out   <= '0;
      r_error_valid <= 1'b0;
      r_sync_loss   <= 1'b0;
      r_error_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_seed        <= w_seed_next;
      r_good        <= w_good_next;
      r_bad         <= w_bad_next;
      r_error_out   <= w_error_out_next;
      r_error_valid <= w_error_valid_next;
      r_sync_loss   <= w_sync_loss_next;
      r_error_count <= w_error_count_next;
    end
  end

  assign locked      = (r_state == ST_LOCKED);
  assign error_out   = r_error_out;
  assign error_valid = r_error_valid;
  assign error_count = r_error_count;
  assign sync_loss   = r_sync_loss;

endmodule
